// File: rtl/cache_coherence_port_pkg.sv
// Purpose : shared field ranges, line packing and FSM encodings for the coherence port.
// Latency : n/a (types, constants and a pure helper function only).
// Backpres: n/a.
package cache_coherence_port_pkg;

  // Coherence message: {valid, block[15:0], address[15:0]}
  localparam int MSG_VLD    = 32;
  localparam int MSG_BLK_HI = 31;
  localparam int MSG_BLK_LO = 16;
  localparam int MSG_ADR_HI = 15;
  localparam int MSG_ADR_LO = 0;
  localparam int MSG_TAG_HI = 15;
  localparam int MSG_TAG_LO = 8;
  localparam int MSG_IDX_HI = 7;
  localparam int MSG_IDX_LO = 1;
  localparam int MSG_OFS    = 0;

  // Cache line as seen on the array port: {valid, tag[7:0], data[15:0]}
  localparam int LINE_VLD    = 24;
  localparam int LINE_TAG_HI = 23;
  localparam int LINE_TAG_LO = 16;
  localparam int LINE_DAT_HI = 15;
  localparam int LINE_DAT_LO = 0;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [15:0] data;
  } line_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // A line matches a snoop only if it is valid and holds the same tag.
  function automatic logic line_hit(input logic [24:0] line, input logic [7:0] tag);
    return line[LINE_VLD] && (line[LINE_TAG_HI:LINE_TAG_LO] == tag);
  endfunction

endpackage

// File: rtl/coherence_msg_fifo.sv
// Purpose : DEPTH x WIDTH receive buffer for incoming coherence messages.
// Latency : head visible the cycle after a push into an empty FIFO.
// Backpres: none upstream; push into full FIFO is ignored unless a pop happens the same cycle.
// Ports   : clock/reset, push+push_dat in, pop in, pop_dat (head), full, empty out.
module coherence_msg_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/cache_coherence_port.sv
// Purpose : cache-side coherence endpoint; sends local write changes, applies remote ones.
// Latency : tx 1 cycle; rx grant -> READ -> WRITE strobe on a hit.
// Backpres: array_req waits on array_grant; FIFO overflow drops and sets sticky overflow.
// Ports   : local_write_* in, cache_change out; coherence_in in; array_* handshake to the
//           cache array; snoop_busy stalls the controller; overflow is sticky until reset.
module cache_coherence_port
  import cache_coherence_port_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter bit MODE_UPDATE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        local_write_valid,
  input  logic [15:0] local_write_addr,
  input  logic [15:0] local_write_block,
  output logic [32:0] cache_change,
  input  logic [32:0] coherence_in,
  output logic        snoop_busy,
  output logic        array_req,
  input  logic        array_grant,
  output logic [6:0]  array_index,
  input  logic [24:0] array_rdata,
  output logic        array_we,
  output logic [24:0] array_wdata,
  output logic        overflow
);

  state_t      state_q, state_d;
  logic        pop;
  logic        full;
  logic        empty;
  logic [31:0] head;
  logic [15:0] work_blk;
  logic [7:0]  work_tag;
  logic [6:0]  work_idx;
  line_t       line_q;
  logic        unused_bits;

  // Transmit path: a registered one-cycle message per committed write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_change <= '0;
    end else begin
      cache_change <= '0;
      if (local_write_valid) begin
        cache_change[MSG_VLD]                <= 1'b1;
        cache_change[MSG_BLK_HI:MSG_BLK_LO] <= local_write_block;
        cache_change[MSG_ADR_HI:MSG_ADR_LO] <= local_write_addr;
      end
    end
  end

  coherence_msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (coherence_in[MSG_VLD]),
    .push_dat (coherence_in[MSG_BLK_HI:MSG_ADR_LO]),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (coherence_in[MSG_VLD] && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      work_blk <= '0;
      work_tag <= '0;
      work_idx <= '0;
      line_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        work_blk <= head[MSG_BLK_HI:MSG_BLK_LO];
        work_tag <= head[MSG_TAG_HI:MSG_TAG_LO];
        work_idx <= head[MSG_IDX_HI:MSG_IDX_LO];
      end
      if (state_q == ST_READ) line_q <= line_t'(array_rdata);
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    array_req   = 1'b0;
    array_index = '0;
    array_we    = 1'b0;
    array_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        // Head stays queued until the array is ours, so nothing is lost while waiting.
        array_req   = 1'b1;
        array_index = head[MSG_IDX_HI:MSG_IDX_LO];
        if (array_grant) begin
          pop     = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = line_hit(array_rdata, work_tag) ? ST_WRITE : ST_IDLE;
      end
      ST_WRITE: begin
        array_we                             = 1'b1;
        array_index                          = work_idx;
        array_wdata[LINE_VLD]                = MODE_UPDATE;
        array_wdata[LINE_TAG_HI:LINE_TAG_LO] = line_q.tag;
        array_wdata[LINE_DAT_HI:LINE_DAT_LO] = MODE_UPDATE ? work_blk : line_q.data;
        state_d                              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Both terms are registers, keeping coherence_in off any combinational path here.
  assign snoop_busy = !empty || (state_q != ST_IDLE);

  // Offset bit and the captured valid/data bits are not needed in every mode.
  assign unused_bits = ^{head[MSG_OFS], line_q.valid, line_q.data};

endmodule
